// File: rtl/gate2_exerciser.sv
// ============================================================================
// gate2_exerciser: drives a 2-input gate through all four vectors, checks
// each sampled output against TRUTH and reports pass/err_count/fail_vec.
// Revision: 1.0
// ============================================================================
`default_nettype none

module gate2_exerciser #(
  parameter logic [3:0]  TRUTH  = 4'b0110,
  parameter int unsigned SETTLE = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       gate_out,
  output logic       gate_a,
  output logic       gate_b,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [2:0] err_count,
  output logic [3:0] fail_vec
);

  localparam logic [3:0] C_SETTLE = 4'(SETTLE);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t     state_q, state_d;
  logic [1:0] idx_q, idx_d;
  logic [3:0] cnt_q, cnt_d;
  logic [1:0] ab_q, ab_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;
  logic       pass_q, pass_d;
  logic [2:0] err_q, err_d;
  logic [3:0] fail_q, fail_d;
  logic       w_miss;

  assign w_miss = (gate_out != TRUTH[idx_q]);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      idx_q   <= 2'd0;
      cnt_q   <= 4'd0;
      ab_q    <= 2'd0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
      err_q   <= 3'd0;
      fail_q  <= 4'd0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      ab_q    <= ab_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      pass_q  <= pass_d;
      err_q   <= err_d;
      fail_q  <= fail_d;
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    ab_d    = ab_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    pass_d  = pass_q;
    err_d   = err_q;
    fail_d  = fail_q;

    case (state_q)
      // The done cycle accepts start exactly like idle, so a held start
      // restarts on the edge right after done.
      S_IDLE, S_DONE: begin
        ab_d   = 2'd0;
        busy_d = 1'b0;
        if (start) begin
          state_d = S_RUN;
          idx_d   = 2'd0;
          cnt_d   = 4'd0;
          busy_d  = 1'b1;
          pass_d  = 1'b0;
          err_d   = 3'd0;
          fail_d  = 4'd0;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_RUN: begin
        if (cnt_q == C_SETTLE) begin
          cnt_d = 4'd0;
          if (w_miss) begin
            fail_d[idx_q] = 1'b1;
            err_d         = err_q + 3'd1;
          end
          if (idx_q == 2'd3) begin
            state_d = S_DONE;
            idx_d   = 2'd0;
            ab_d    = 2'd0;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            pass_d  = (err_q == 3'd0) && !w_miss;
          end else begin
            idx_d = idx_q + 2'd1;
            ab_d  = idx_q + 2'd1;
          end
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      default: begin
        state_d = S_IDLE;
        ab_d    = 2'd0;
        busy_d  = 1'b0;
      end
    endcase
  end

  assign gate_a    = ab_q[1];
  assign gate_b    = ab_q[0];
  assign busy      = busy_q;
  assign done      = done_q;
  assign pass      = pass_q;
  assign err_count = err_q;
  assign fail_vec  = fail_q;

endmodule

`default_nettype wire

// File: tb/tb_gate2_exerciser.sv
// ============================================================================
// tb_gate2_exerciser: scoreboard bench for gate2_exerciser (SETTLE=2 and 1).
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_gate2_exerciser;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start2 = 1'b0, start1 = 1'b0;
  logic       go2, go1;
  logic       a2, b2, busy2, done2, pass2;
  logic       a1, b1, busy1, done1, pass1;
  logic [2:0] ec2, ec1;
  logic [3:0] fv2, fv1;
  int         mode2 = 0, mode1 = 0;
  logic       p1_2 = 1'b0, p2_2 = 1'b0, p1_1 = 1'b0, p2_1 = 1'b0;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [3:0] fv;
    logic [2:0] ec;
    logic       p;
  } exp_t;
  exp_t sb[$];

  always #5 clk = ~clk;

  // Gates under test: 0 xor, 1 stuck-0, 2 and, 3 xor behind two registers
  always_ff @(posedge clk) begin
    p1_2 <= a2 ^ b2;
    p2_2 <= p1_2;
    p1_1 <= a1 ^ b1;
    p2_1 <= p1_1;
  end

  always_comb begin
    case (mode2)
      1:       go2 = 1'b0;
      2:       go2 = a2 & b2;
      3:       go2 = p2_2;
      default: go2 = a2 ^ b2;
    endcase
    case (mode1)
      1:       go1 = 1'b0;
      2:       go1 = a1 & b1;
      3:       go1 = p2_1;
      default: go1 = a1 ^ b1;
    endcase
  end

  gate2_exerciser #(.TRUTH(4'b0110), .SETTLE(2)) u_s2 (
    .clk(clk), .rst(rst), .start(start2), .gate_out(go2),
    .gate_a(a2), .gate_b(b2), .busy(busy2), .done(done2),
    .pass(pass2), .err_count(ec2), .fail_vec(fv2)
  );

  gate2_exerciser #(.TRUTH(4'b0110), .SETTLE(1)) u_s1 (
    .clk(clk), .rst(rst), .start(start1), .gate_out(go1),
    .gate_a(a1), .gate_b(b1), .busy(busy1), .done(done1),
    .pass(pass1), .err_count(ec1), .fail_vec(fv1)
  );

  // Output seen at vector k; a lagging pipeline shows vector k-1 (idle 00 for k=0)
  function automatic logic model_out(input int mode, input bit lag, input int k);
    logic [1:0] v;
    v = k[1:0];
    if (mode == 3 && lag) v = (k == 0) ? 2'd0 : 2'(k - 1);
    case (mode)
      1:       return 1'b0;
      2:       return v[1] & v[0];
      default: return v[1] ^ v[0];
    endcase
  endfunction

  task automatic push_expected(input int mode, input bit lag);
    exp_t       e;
    logic [3:0] truth;
    truth = 4'b0110;
    e.fv  = 4'd0;
    e.ec  = 3'd0;
    for (int k = 0; k < 4; k++) begin
      if (model_out(mode, lag, k) != truth[k]) begin
        e.fv[k] = 1'b1;
        e.ec    = e.ec + 3'd1;
      end
    end
    e.p = (e.ec == 3'd0);
    sb.push_back(e);
  endtask

  task automatic pulse_start(input int which);
    if (which == 1) start1 = 1'b1; else start2 = 1'b1;
    @(posedge clk); #1;
    start1 = 1'b0;
    start2 = 1'b0;
  endtask

  // Waits up to 100 edges for done; cyc counts edges since the call
  task automatic wait_done(input int which, output int cyc, output bit to);
    cyc = 0;
    to  = 1'b1;
    for (int i = 0; i < 100 && to; i++) begin
      @(posedge clk); #1;
      cyc++;
      if ((which == 1) ? done1 : done2) to = 1'b0;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({a2, b2, busy2, done2, pass2, ec2, fv2} !== 13'd0) begin
      errors++;
      $display("FAIL reset_s2: got %h expected 0", {a2, b2, busy2, done2, pass2, ec2, fv2});
    end
    checks++;
    if ({a1, b1, busy1, done1, pass1, ec1, fv1} !== 13'd0) begin
      errors++;
      $display("FAIL reset_s1: got %h expected 0", {a1, b1, busy1, done1, pass1, ec1, fv1});
    end
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic test_xor();
    exp_t e;
    mode2 = 0;
    push_expected(0, 1'b0);
    pulse_start(2);
    for (int j = 0; j < 12; j++) begin
      checks++;
      if ({busy2, done2, a2, b2, pass2, ec2, fv2} !== {1'b1, 1'b0, 2'(j / 3), 8'd0}) begin
        errors++;
        $display("FAIL xor_run_cycle%0d: got busy=%b done=%b ab=%b res=%h expected busy=1 done=0 ab=%0d res=0",
                 j, busy2, done2, {a2, b2}, {pass2, ec2, fv2}, j / 3);
      end
      @(posedge clk); #1;
    end
    checks++;
    if ({done2, busy2, a2, b2} !== 4'b1000) begin
      errors++;
      $display("FAIL xor_done_edge: got done/busy/a/b=%b expected 1000", {done2, busy2, a2, b2});
    end
    checks++;
    if (sb.size() == 0) begin
      errors++;
      $display("FAIL xor_sb_empty: got 0 entries expected 1");
    end else begin
      e = sb.pop_front();
      if ({fv2, ec2, pass2} !== {e.fv, e.ec, e.p}) begin
        errors++;
        $display("FAIL xor_result: got fv=%b ec=%0d pass=%b expected fv=%b ec=%0d pass=%b",
                 fv2, ec2, pass2, e.fv, e.ec, e.p);
      end
    end
    @(posedge clk); #1;
    checks++;
    if ({done2, busy2, pass2, ec2, fv2} !== {3'b001, 7'd0}) begin
      errors++;
      $display("FAIL xor_after_done: got %b expected 0010000000", {done2, busy2, pass2, ec2, fv2});
    end
  endtask

  task automatic test_stuck_zero();
    exp_t e;
    int   cyc;
    bit   to;
    mode2 = 1;
    push_expected(1, 1'b0);
    pulse_start(2);
    wait_done(2, cyc, to);
    checks++;
    if (to || cyc != 12) begin
      errors++;
      $display("FAIL zero_latency: got %0d cycles (timeout=%b) expected 12", cyc, to);
    end
    e = sb.pop_front();
    checks++;
    if ({fv2, ec2, pass2} !== {e.fv, e.ec, e.p}) begin
      errors++;
      $display("FAIL zero_result: got fv=%b ec=%0d pass=%b expected fv=%b ec=%0d pass=%b",
               fv2, ec2, pass2, e.fv, e.ec, e.p);
    end
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      checks++;
      if ({busy2, done2, fv2, ec2, pass2} !== {2'b00, e.fv, e.ec, e.p}) begin
        errors++;
        $display("FAIL zero_hold_%0d: got busy=%b done=%b fv=%b ec=%0d pass=%b expected 0 0 %b %0d %b",
                 i, busy2, done2, fv2, ec2, pass2, e.fv, e.ec, e.p);
      end
    end
  endtask

  task automatic test_and();
    exp_t e;
    int   cyc;
    bit   to;
    mode2 = 2;
    push_expected(2, 1'b0);
    pulse_start(2);
    wait_done(2, cyc, to);
    e = sb.pop_front();
    checks++;
    if (to || {fv2, ec2, pass2} !== {e.fv, e.ec, e.p}) begin
      errors++;
      $display("FAIL and_result: got fv=%b ec=%0d pass=%b (timeout=%b) expected fv=%b ec=%0d pass=%b",
               fv2, ec2, pass2, to, e.fv, e.ec, e.p);
    end
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic test_pipeline();
    exp_t e;
    int   cyc;
    bit   to;
    mode1 = 3;
    mode2 = 3;
    repeat (4) @(posedge clk);
    #1;
    push_expected(3, 1'b1);
    pulse_start(1);
    wait_done(1, cyc, to);
    e = sb.pop_front();
    checks++;
    if (to || cyc != 8 || {fv1, ec1, pass1} !== {e.fv, e.ec, e.p}) begin
      errors++;
      $display("FAIL pipe_settle1: got fv=%b ec=%0d pass=%b cyc=%0d expected fv=%b ec=%0d pass=%b cyc=8",
               fv1, ec1, pass1, cyc, e.fv, e.ec, e.p);
    end
    push_expected(3, 1'b0);
    pulse_start(2);
    wait_done(2, cyc, to);
    e = sb.pop_front();
    checks++;
    if (to || {fv2, ec2, pass2} !== {e.fv, e.ec, e.p}) begin
      errors++;
      $display("FAIL pipe_settle2: got fv=%b ec=%0d pass=%b expected fv=%b ec=%0d pass=%b",
               fv2, ec2, pass2, e.fv, e.ec, e.p);
    end
    mode1 = 0;
    mode2 = 0;
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic test_busy_start_and_reset();
    exp_t e;
    int   cyc;
    int   bad;
    bit   to;
    push_expected(0, 1'b0);
    pulse_start(2);
    repeat (4) @(posedge clk);
    #1;
    pulse_start(2);
    wait_done(2, cyc, to);
    e = sb.pop_front();
    checks++;
    if (to || cyc != 7 || {fv2, ec2, pass2} !== {e.fv, e.ec, e.p}) begin
      errors++;
      $display("FAIL ignore_start: got cyc=%0d fv=%b ec=%0d pass=%b expected cyc=7 fv=%b ec=%0d pass=%b",
               cyc, fv2, ec2, pass2, e.fv, e.ec, e.p);
    end
    @(posedge clk); #1;
    checks++;
    if (busy2 !== 1'b0) begin
      errors++;
      $display("FAIL ignore_no_queue: got busy=%b expected 0", busy2);
    end
    pulse_start(2);
    repeat (4) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    checks++;
    if ({a2, b2, busy2, done2, pass2, ec2, fv2} !== 13'd0) begin
      errors++;
      $display("FAIL midrun_reset: got %h expected 0", {a2, b2, busy2, done2, pass2, ec2, fv2});
    end
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (done2 !== 1'b0 || busy2 !== 1'b0) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL midrun_no_done: got %0d active cycles expected 0", bad);
    end
    push_expected(0, 1'b0);
    pulse_start(2);
    wait_done(2, cyc, to);
    e = sb.pop_front();
    checks++;
    if (to || cyc != 12 || {fv2, ec2, pass2} !== {e.fv, e.ec, e.p}) begin
      errors++;
      $display("FAIL post_reset_run: got cyc=%0d fv=%b ec=%0d pass=%b expected cyc=12 fv=%b ec=%0d pass=%b",
               cyc, fv2, ec2, pass2, e.fv, e.ec, e.p);
    end
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic test_back_to_back();
    exp_t e;
    int   cyc;
    bit   to;
    mode2  = 0;
    start2 = 1'b1;
    @(posedge clk); #1;
    for (int r = 0; r < 3; r++) begin
      push_expected(0, 1'b0);
      wait_done(2, cyc, to);
      e = sb.pop_front();
      checks++;
      if (to || cyc != 12 || {fv2, ec2, pass2} !== {e.fv, e.ec, e.p}) begin
        errors++;
        $display("FAIL b2b_run%0d: got cyc=%0d fv=%b ec=%0d pass=%b expected cyc=12 fv=%b ec=%0d pass=%b",
                 r, cyc, fv2, ec2, pass2, e.fv, e.ec, e.p);
      end
      if (r == 2) start2 = 1'b0;
      @(posedge clk); #1;
      checks++;
      if (r < 2) begin
        if ({done2, busy2, pass2} !== 3'b010) begin
          errors++;
          $display("FAIL b2b_reaccept%0d: got done/busy/pass=%b expected 010", r, {done2, busy2, pass2});
        end
      end else begin
        if ({done2, busy2, pass2} !== 3'b001) begin
          errors++;
          $display("FAIL b2b_final_hold: got done/busy/pass=%b expected 001", {done2, busy2, pass2});
        end
      end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_xor();
    test_stuck_zero();
    test_and();
    test_pipeline();
    test_busy_start_and_reset();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
